// File: rtl/wb_nor_arbiter_pkg.sv
// wb_nor_arbiter_pkg: shared state encodings and default watchdog limit for the NOR arbiter
package wb_nor_arbiter_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT0  = 2'd1,
    ARB_GNT1  = 2'd2,
    ARB_ABORT = 2'd3
  } arb_state_e;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;
endpackage

// File: rtl/wb_nor_arbiter_outst_counter.sv
// wb_outst_counter: saturating-at-zero up/down counter with clear and full flag
module wb_outst_counter #(
  parameter int          W   = 4,
  parameter int unsigned MAX = (1 << W) - 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt_o,
  output logic         full_o
);
  logic [W-1:0] cnt_q, cnt_d;
  // clear wins; simultaneous inc/dec cancel; a decrement at zero is a spurious response
  always_comb begin
    cnt_d = clr ? '0 :
            (inc & ~dec) ? cnt_q + W'(1) :
            (dec & ~inc & (cnt_q != '0)) ? cnt_q - W'(1) : cnt_q;
    cnt_o = cnt_q;
    full_o = cnt_q == W'(MAX);
  end
  // count register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/wb_nor_arbiter.sv
// wb_nor_arbiter: two-master round-robin Wishbone arbiter; optional ack watchdog via WB_NOR_ARB_TIMEOUT_EN
module wb_nor_arbiter
  import wb_nor_arbiter_pkg::*;
#(
  parameter int          ADDRBITS       = 32,
  parameter int          DATABITS       = 16,
  parameter int          OUTST_BITS     = 4,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wbs0_cyc_i,
  input  logic                wbs0_stb_i,
  input  logic                wbs0_we_i,
  input  logic [ADDRBITS-1:0] wbs0_adr_i,
  input  logic [DATABITS-1:0] wbs0_dat_i,
  output logic [DATABITS-1:0] wbs0_dat_o,
  output logic                wbs0_ack_o,
  output logic                wbs0_err_o,
  output logic                wbs0_stall_o,
  input  logic                wbs1_cyc_i,
  input  logic                wbs1_stb_i,
  input  logic                wbs1_we_i,
  input  logic [ADDRBITS-1:0] wbs1_adr_i,
  input  logic [DATABITS-1:0] wbs1_dat_i,
  output logic [DATABITS-1:0] wbs1_dat_o,
  output logic                wbs1_ack_o,
  output logic                wbs1_err_o,
  output logic                wbs1_stall_o,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [ADDRBITS-1:0] wbm_adr_o,
  output logic [DATABITS-1:0] wbm_dat_o,
  input  logic [DATABITS-1:0] wbm_dat_i,
  input  logic                wbm_ack_i,
  input  logic                wbm_err_i,
  input  logic                wbm_stall_i,
  output logic [1:0]          gnt_o,
  output logic                timeout_o
);
  arb_state_e state_q, state_d;
  logic last_q, last_d;
  logic g0, g1, granted, sel, cyc_s, stb_s, rel, rsp, acc, full, fire;
  logic [OUTST_BITS-1:0] outst;
  // in ABORT the stuck master is the one recorded in last_q
  always_comb begin
    g0 = state_q == ARB_GNT0;
    g1 = state_q == ARB_GNT1;
    granted = g0 | g1;
    sel = g1 | ((state_q == ARB_ABORT) & last_q);
    cyc_s = sel ? wbs1_cyc_i : wbs0_cyc_i;
    stb_s = sel ? wbs1_stb_i : wbs0_stb_i;
    rel = granted & ~cyc_s;
    rsp = wbm_ack_i | wbm_err_i;
    wbm_cyc_o = granted & cyc_s;
    wbm_stb_o = granted & stb_s & ~full;
    wbm_we_o = granted & (sel ? wbs1_we_i : wbs0_we_i);
    wbm_adr_o = granted ? (sel ? wbs1_adr_i : wbs0_adr_i) : '0;
    wbm_dat_o = granted ? (sel ? wbs1_dat_i : wbs0_dat_i) : '0;
    acc = wbm_stb_o & ~wbm_stall_i;
    wbs0_stall_o = g0 ? (wbm_stall_i | full) : 1'b1;
    wbs1_stall_o = g1 ? (wbm_stall_i | full) : 1'b1;
    wbs0_ack_o = g0 & wbm_ack_i;
    wbs1_ack_o = g1 & wbm_ack_i;
    wbs0_err_o = g0 & (wbm_err_i | fire);
    wbs1_err_o = g1 & (wbm_err_i | fire);
    wbs0_dat_o = g0 ? wbm_dat_i : '0;
    wbs1_dat_o = g1 ? wbm_dat_i : '0;
    gnt_o = {g1, g0};
    timeout_o = fire;
  end
  // arbitration: tie goes to the master not served last; release always passes through IDLE
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    case (state_q)
      ARB_IDLE: state_d = (wbs0_cyc_i & (~wbs1_cyc_i | last_q)) ? ARB_GNT0 :
                          wbs1_cyc_i ? ARB_GNT1 : ARB_IDLE;
      ARB_GNT0, ARB_GNT1: begin
        state_d = rel ? ARB_IDLE : fire ? ARB_ABORT : state_q;
        last_d = (rel | fire) ? g1 : last_q;
      end
      default: state_d = cyc_s ? ARB_ABORT : ARB_IDLE;
    endcase
  end
  // state and fairness registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ARB_IDLE;
      last_q <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
    end
  end
  wb_outst_counter #(.W(OUTST_BITS)) u_outst (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .clr   (~granted | rel | fire),
    .inc   (acc),
    .dec   (rsp),
    .cnt_o (outst),
    .full_o(full)
  );
`ifdef WB_NOR_ARB_TIMEOUT_EN
  localparam int WD_BITS = $clog2(TIMEOUT_CYCLES + 1);
  logic wd_en, wd_full, unused_wd;
  logic [WD_BITS-1:0] wd_cnt;
  assign wd_en = granted & (outst != '0) & ~rsp;
  wb_outst_counter #(.W(WD_BITS), .MAX(TIMEOUT_CYCLES - 1)) u_wd (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .clr   (~wd_en),
    .inc   (wd_en),
    .dec   (1'b0),
    .cnt_o (wd_cnt),
    .full_o(wd_full)
  );
  assign fire = wd_en & wd_full;
  assign unused_wd = ^wd_cnt;
`else
  logic unused_wd;
  assign unused_wd = ^{outst, TIMEOUT_CYCLES};
  assign fire = 1'b0;
`endif
endmodule

// File: tb/tb_wb_nor_arbiter.sv
// tb_wb_nor_arbiter: directed self-checking bench for wb_nor_arbiter (OUTST_BITS=2, TIMEOUT_CYCLES=16)
module tb_wb_nor_arbiter;
`ifdef WB_NOR_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  logic cyc0, stb0, we0, cyc1, stb1, we1;
  logic [31:0] adr0, adr1;
  logic [15:0] wdat0, wdat1, rdat0, rdat1, m_wdat, m_rdat;
  logic ack0, err0, stall0, ack1, err1, stall1;
  logic m_cyc, m_stb, m_we, m_ack, m_err, m_stall;
  logic [31:0] m_adr;
  logic [1:0] gnt;
  logic tmo;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_nor_arbiter #(.ADDRBITS(32), .DATABITS(16), .OUTST_BITS(2), .TIMEOUT_CYCLES(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs0_cyc_i(cyc0), .wbs0_stb_i(stb0), .wbs0_we_i(we0), .wbs0_adr_i(adr0), .wbs0_dat_i(wdat0),
    .wbs0_dat_o(rdat0), .wbs0_ack_o(ack0), .wbs0_err_o(err0), .wbs0_stall_o(stall0),
    .wbs1_cyc_i(cyc1), .wbs1_stb_i(stb1), .wbs1_we_i(we1), .wbs1_adr_i(adr1), .wbs1_dat_i(wdat1),
    .wbs1_dat_o(rdat1), .wbs1_ack_o(ack1), .wbs1_err_o(err1), .wbs1_stall_o(stall1),
    .wbm_cyc_o(m_cyc), .wbm_stb_o(m_stb), .wbm_we_o(m_we), .wbm_adr_o(m_adr), .wbm_dat_o(m_wdat),
    .wbm_dat_i(m_rdat), .wbm_ack_i(m_ack), .wbm_err_i(m_err), .wbm_stall_i(m_stall),
    .gnt_o(gnt), .timeout_o(tmo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    {cyc0, stb0, we0, cyc1, stb1, we1} = '0;
    adr0 = '0; adr1 = '0; wdat0 = '0; wdat1 = '0;
    m_rdat = '0; m_ack = 0; m_err = 0; m_stall = 0;
    rst = 1;
    tick();
    tick();
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_mcyc", m_cyc, 0);
    chk("rst_mstb", m_stb, 0);
    chk("rst_madr", m_adr, 0);
    chk("rst_stall0", stall0, 1);
    chk("rst_stall1", stall1, 1);
    chk("rst_ack0", ack0, 0);
    chk("rst_err1", err1, 0);
    chk("rst_tmo", tmo, 0);
    rst = 0;
    // single read by m0
    cyc0 = 1; stb0 = 1; adr0 = 32'h100;
    #1;
    chk("t1_gnt_lat", gnt, 2'b00);
    tick();
    chk("t1_gnt", gnt, 2'b01);
    chk("t1_mstb", m_stb, 1);
    chk("t1_madr", m_adr, 32'h100);
    chk("t1_stall0", stall0, 0);
    chk("t1_stall1", stall1, 1);
    tick();
    stb0 = 0;
    tick();
    tick();
    m_ack = 1; m_rdat = 16'hBEEF;
    #1;
    chk("t1_ack0", ack0, 1);
    chk("t1_dat0", rdat0, 16'hBEEF);
    chk("t1_ack1", ack1, 0);
    chk("t1_dat1", rdat1, 0);
    chk("t1_stall1b", stall1, 1);
    tick();
    m_ack = 0; m_rdat = 0; cyc0 = 0;
    #1;
    chk("t1_mcyc_drop", m_cyc, 0);
    tick();
    chk("t1_idle", gnt, 2'b00);
    // round robin from a fresh reset
    rst = 1;
    tick();
    rst = 0;
    cyc0 = 1; cyc1 = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_gnt", gnt, (i % 2) ? 2'b10 : 2'b01);
      if (i % 2) stb1 = 1; else stb0 = 1;
      tick();
      stb0 = 0; stb1 = 0; m_ack = 1;
      #1;
      chk("rr_ack", (i % 2) ? ack1 : ack0, 1);
      tick();
      m_ack = 0;
      if (i % 2) cyc1 = 0; else cyc0 = 0;
      tick();
      chk("rr_idle", gnt, 2'b00);
      if (i % 2) cyc1 = 1; else cyc0 = 1;
    end
    cyc0 = 0; cyc1 = 0;
    tick();
    // m1 streams with no acks: pipeline depth bounded at 3
    cyc1 = 1; stb1 = 1;
    tick();
    chk("st_gnt", gnt, 2'b10);
    chk("st_stall1_0", stall1, 0);
    tick();
    tick();
    chk("st_stall1_2", stall1, 0);
    tick();
    chk("st_full_stall", stall1, 1);
    chk("st_full_stb", m_stb, 0);
    chk("st_stall0", stall0, 1);
    tick();
    chk("st_full_hold", stall1, 1);
    m_ack = 1;
    #1;
    chk("st_ack_full", stall1, 1);
    chk("st_ack1", ack1, 1);
    tick();
    m_ack = 0;
    #1;
    chk("st_slot_free", stall1, 0);
    chk("st_slot_stb", m_stb, 1);
    tick();
    chk("st_refull", stall1, 1);
    // simultaneous ack and accepted stb at outstanding=2
    m_ack = 1;
    tick();
    chk("sim_pre_stall", stall1, 0);
    chk("sim_pre_stb", m_stb, 1);
    tick();
    m_ack = 0;
    #1;
    chk("sim_hold_stall", stall1, 0);
    tick();
    chk("sim_full", stall1, 1);
    stb1 = 0; cyc1 = 0;
    tick();
    // m0 abandons a cycle with one transfer outstanding
    cyc0 = 1; stb0 = 1;
    tick();
    chk("ab_gnt", gnt, 2'b01);
    tick();
    stb0 = 0; cyc0 = 0;
    #1;
    chk("ab_mcyc", m_cyc, 0);
    tick();
    chk("ab_idle", gnt, 2'b00);
    tick();
    m_ack = 1; cyc1 = 1;
    #1;
    chk("ab_ack0", ack0, 0);
    chk("ab_ack1", ack1, 0);
    chk("ab_gnt_idle", gnt, 2'b00);
    tick();
    m_ack = 0;
    chk("ab_m1_gnt", gnt, 2'b10);
    chk("ab_m1_stall", stall1, 0);
    cyc1 = 0;
    tick();
    // ack watchdog
    cyc0 = 1; stb0 = 1;
    tick();
    chk("wd_gnt", gnt, 2'b01);
    tick();
    stb0 = 0;
    for (int i = 1; i <= 16; i++) begin
      #1;
      chk("wd_err0", err0, (i == 16) ? 32'(TO_EN) : 32'd0);
      chk("wd_tmo", tmo, (i == 16) ? 32'(TO_EN) : 32'd0);
      tick();
    end
    chk("wd_after_mcyc", m_cyc, TO_EN ? 0 : 1);
    chk("wd_after_gnt", gnt, TO_EN ? 2'b00 : 2'b01);
    chk("wd_after_stall0", stall0, TO_EN ? 1 : 0);
    chk("wd_after_err0", err0, 0);
    chk("wd_after_tmo", tmo, 0);
    tick();
    chk("wd_hold_mcyc", m_cyc, TO_EN ? 0 : 1);
    cyc0 = 0;
    tick();
    chk("wd_end_gnt", gnt, 2'b00);
    chk("wd_end_mcyc", m_cyc, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_nor_arbiter.md
Name: wb_nor_arbiter

Overview:
Two-master pipelined Wishbone arbiter sitting in front of wb_nor_controller's slave port. It shares the NOR controller between the QSPI command FSM (master 0) and a second requester, such as a background scrub or readback engine (master 1). Grants are round-robin and held for a whole bus cycle (CYC). The arbiter tracks outstanding transfers so it can bound the pipeline depth and release the grant cleanly.

Parameters:
ADDRBITS, 32, Wishbone address width, matching the controller slave port
DATABITS, 16, Wishbone data width
OUTST_BITS, 4, width of the outstanding-transfer counter; max outstanding = 2**OUTST_BITS-1
TIMEOUT_CYCLES, 1024, ack watchdog limit; used only with the optional feature

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous active-high reset
wbs0_cyc_i, wbs0_stb_i, wbs0_we_i  in  1 each  master 0 control
wbs0_adr_i  in  ADDRBITS  master 0 address
wbs0_dat_i  in  DATABITS  master 0 write data
wbs0_dat_o  out  DATABITS  master 0 read data
wbs0_ack_o, wbs0_err_o, wbs0_stall_o  out  1 each  master 0 response
wbs1_*  same set as wbs0_*  master 1
wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  to controller
wbm_adr_o  out  ADDRBITS  to controller
wbm_dat_o  out  DATABITS  to controller
wbm_dat_i  in  DATABITS  from controller
wbm_ack_i, wbm_err_i, wbm_stall_i  in  1 each  from controller
gnt_o  out  2  one-hot grant; 00 when idle
timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Clock and reset: single clock wb_clk_i; reset wb_rst_i is synchronous and active-high.
- States: IDLE, GNT0, GNT1, ABORT.
- Registered state; reset to IDLE from any state, including mid-transfer.
- Reset values:
  - gnt_o=00, outstanding=0, watchdog=0, last_gnt=1 (so master 0 wins the first tie).
  - All wbm_* outputs 0.
  - All ack/err outputs 0; both stall outputs 1.
- IDLE:
  - Only cyc0 high -> GNT0. Only cyc1 high -> GNT1.
  - Both high -> grant the master that is not last_gnt.
  - Grant takes effect the cycle after CYC is seen, i.e. 1-cycle arbitration latency.
- GNTn, bus routing:
  - wbm_cyc/stb/we/adr/dat are driven combinationally from master n.
  - wbm_stb_o = stb_n & ~full.
  - wbsn_stall_o = wbm_stall_i | full.
  - wbsn_ack_o / wbsn_err_o / wbsn_dat_o pass through from the controller.
  - The non-granted master sees stall=1, ack=0, err=0, dat=0.
- GNTn, release:
  - When cyc_n drops -> IDLE, and last_gnt <= n.
  - wbm_cyc_o falls in the same cycle (abort semantics).
  - outstanding is cleared; acks/errs arriving after release are dropped and never routed to any master.
- Outstanding counter:
  - +1 on (wbm_stb_o & ~wbm_stall_i); -1 on (wbm_ack_i | wbm_err_i).
  - Both in one cycle -> unchanged.
  - full = (outstanding == max).
  - Decrement at 0 is ignored (spurious ack).
- No back-to-back bypass: after a release, at least one IDLE cycle precedes the next grant.
- ABORT is reachable only with the optional feature:
  - wbm_cyc_o=0; the granted master sees stall=1.
  - Stay in ABORT until that master's cyc drops, then -> IDLE.

Optional Feature:
Macro WB_NOR_ARB_TIMEOUT_EN.
- Defined:
  - The watchdog counts while in GNTn with outstanding>0 and no ack/err; it clears on ack/err or on leaving GNTn.
  - On reaching TIMEOUT_CYCLES: assert wbsn_err_o for one cycle, pulse timeout_o, clear outstanding, go to ABORT.
- Not defined: no watchdog logic, timeout_o tied 0, ABORT unreachable.

Decomposition:
- Shared package / header (wb_defs.vh, alongside cmd_defs.vh):
  - State encodings ARB_IDLE/ARB_GNT0/ARB_GNT1/ARB_ABORT.
  - Default TIMEOUT_CYCLES.
- One natural sub-module, wb_outst_counter: up/down counter with full flag and underflow guard. Also reused by the watchdog clear logic.
- The mux stays inline.

Test Plan:
- Reset, then m0 issues 1 read at adr 0x100; controller acks after 3 cycles with 0xBEEF -> gnt_o=01 one cycle after cyc0; wbs0_dat_o=0xBEEF with ack; wbs1 stall=1 throughout.
- cyc0 and cyc1 rise together, both run 2-cycle transactions, repeated 4 times -> grant order m0,m1,m0,m1; exactly one IDLE cycle between grants.
- m1 streams stb with the controller holding ack low, OUTST_BITS=2 -> exactly 3 accepted; wbs1_stall_o=1 from then on; one ack releases one slot.
- Same cycle ack and new accepted stb at outstanding=2 -> count stays 2; no extra stall.
- m0 drops cyc with 1 outstanding; the controller acks 2 cycles later -> ack not routed to m0 or m1; gnt_o=00; m1 granted next.
- With WB_NOR_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, the controller never acks -> wbs0_err_o and timeout_o pulse on the 16th cycle; wbm_cyc_o=0 until cyc0 drops. Without the macro -> no err; grant held indefinitely.
